// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: FSM encoding, ALU opcodes and counter width.
// Requesters and the ALU use the same opcode list so they agree on the 8:1 result mux inputs.
package alu_share_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_e;

  // wide enough for EXEC_CYCLES-1 with EXEC_CYCLES up to 15
  localparam int EXEC_CNT_W = 4;

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping around.
// Rotates the request vector so ptr+1 lands at bit 0, priority-encodes, then un-rotates.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic             any,
  output logic [PTR_W-1:0] winner
);

  logic [N_REQ-1:0] rot;
  logic [PTR_W-1:0] rot_idx;

  function automatic logic [PTR_W-1:0] wrap(input int v);
    return PTR_W'(v % N_REQ);
  endfunction

  always_comb begin
    rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[wrap(int'(ptr) + 1 + i)];
    end
  end

  // scan downward so the lowest set rotated bit is the one that sticks
  always_comb begin
    any     = 1'b0;
    rot_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        any     = 1'b1;
        rot_idx = PTR_W'(i);
      end
    end
  end

  assign winner = wrap(int'(ptr) + 1 + int'(rot_idx));

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU among N_REQ requesters: latch winner's op/operands,
// hold them EXEC_CYCLES cycles, capture the result and pulse a one-hot ack.
//
// state   | meaning
// IDLE    | waiting for any req; arbitrates and latches the winner's operands
// EXEC    | ALU inputs held; result sampled when the counter reaches zero
// RESP    | ack[grant_id] high for this one cycle; no arbitration
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int WIDTH       = 32,
  parameter  int OP_W        = 3,
  parameter  int EXEC_CYCLES = 1,
  localparam int ID_W        = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*OP_W-1:0]   req_op,
  input  logic [N_REQ*WIDTH-1:0]  req_a,
  input  logic [N_REQ*WIDTH-1:0]  req_b,
  input  logic [WIDTH-1:0]        alu_result,
  output logic [OP_W-1:0]         alu_sel,
  output logic [WIDTH-1:0]        alu_a,
  output logic [WIDTH-1:0]        alu_b,
  output logic [N_REQ-1:0]        ack,
  output logic [WIDTH-1:0]        result,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy
);

  logic [1:0]            state;
  logic [ID_W-1:0]       ptr;
  logic [EXEC_CNT_W-1:0] cnt;
  logic                  pick_any;
  logic [ID_W-1:0]       pick_w;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (ID_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .any    (pick_any),
    .winner (pick_w)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      ptr      <= ID_W'(N_REQ - 1);
      cnt      <= '0;
      alu_sel  <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      ack      <= '0;
      result   <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      ack <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            alu_sel  <= req_op[int'(pick_w)*OP_W +: OP_W];
            alu_a    <= req_a[int'(pick_w)*WIDTH +: WIDTH];
            alu_b    <= req_b[int'(pick_w)*WIDTH +: WIDTH];
            grant_id <= pick_w;
            ptr      <= pick_w;
            cnt      <= EXEC_CNT_W'(EXEC_CYCLES - 1);
            state    <= ST_EXEC;
            busy     <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - EXEC_CNT_W'(1);
          end else begin
            result        <= alu_result;
            ack[grant_id] <= 1'b1;
            state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: two instances (EXEC_CYCLES 1 and 3) against a phase-count
// reference model, directed scenarios with literal expectations, then random traffic.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int OW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]    req        [2];
  logic [N*OW-1:0] req_op     [2];
  logic [N*W-1:0]  req_a      [2];
  logic [N*W-1:0]  req_b      [2];
  logic [W-1:0]    alu_result [2];
  logic [W-1:0]    glitch     [2];
  logic [OW-1:0]   alu_sel    [2];
  logic [W-1:0]    alu_a      [2];
  logic [W-1:0]    alu_b      [2];
  logic [W-1:0]    result     [2];
  logic [N-1:0]    ack        [2];
  logic [1:0]      grant_id   [2];
  logic            busy       [2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  function automatic logic [W-1:0] alu_f(logic [OW-1:0] op, logic [W-1:0] a, logic [W-1:0] b);
    case (alu_op_e'(op))
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLL: return a << b[4:0];
      ALU_SRL: return a >> b[4:0];
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic int ec_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int pick(logic [N-1:0] r, int p);
    for (int j = 1; j <= N; j++) begin
      if (r[(p + j) % N]) return (p + j) % N;
    end
    return -1;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_dut
    alu_share_arbiter #(
      .N_REQ       (N),
      .WIDTH       (W),
      .OP_W        (OW),
      .EXEC_CYCLES (k == 0 ? 1 : 3)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req[k]),
      .req_op     (req_op[k]),
      .req_a      (req_a[k]),
      .req_b      (req_b[k]),
      .alu_result (alu_result[k]),
      .alu_sel    (alu_sel[k]),
      .alu_a      (alu_a[k]),
      .alu_b      (alu_b[k]),
      .ack        (ack[k]),
      .result     (result[k]),
      .grant_id   (grant_id[k]),
      .busy       (busy[k])
    );
    assign alu_result[k] = alu_f(alu_sel[k], alu_a[k], alu_b[k]) ^ glitch[k];
  end

  // reference model: phase 0 idle, 1..EC executing, EC+1 responding
  int            m_phase [2];
  int            m_ptr   [2];
  int            m_gid   [2];
  int            m_win   [2];
  logic [OW-1:0] m_sel   [2];
  logic [W-1:0]  m_a     [2];
  logic [W-1:0]  m_b     [2];
  logic [W-1:0]  m_res   [2];

  always_comb begin
    for (int k = 0; k < 2; k++) m_win[k] = pick(req[k], m_ptr[k]);
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m_phase[k] <= 0;
        m_ptr[k]   <= N - 1;
        m_gid[k]   <= 0;
        m_sel[k]   <= '0;
        m_a[k]     <= '0;
        m_b[k]     <= '0;
        m_res[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_phase[k] == 0) begin
          if (m_win[k] >= 0) begin
            m_gid[k]   <= m_win[k];
            m_ptr[k]   <= m_win[k];
            m_sel[k]   <= req_op[k][m_win[k]*OW +: OW];
            m_a[k]     <= req_a[k][m_win[k]*W +: W];
            m_b[k]     <= req_b[k][m_win[k]*W +: W];
            m_phase[k] <= 1;
          end
        end else if (m_phase[k] <= ec_of(k)) begin
          if (m_phase[k] == ec_of(k)) m_res[k] <= alu_f(m_sel[k], m_a[k], m_b[k]) ^ glitch[k];
          m_phase[k] <= m_phase[k] + 1;
        end else begin
          m_phase[k] <= 0;
        end
      end
    end
  end

  task automatic check(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] ea;
    for (int k = 0; k < 2; k++) begin
      ea = (m_phase[k] == ec_of(k) + 1) ? (N'(1) << m_gid[k]) : '0;
      check($sformatf("alu_sel[%0d]", k), W'(alu_sel[k]), W'(m_sel[k]));
      check($sformatf("alu_a[%0d]", k), alu_a[k], m_a[k]);
      check($sformatf("alu_b[%0d]", k), alu_b[k], m_b[k]);
      check($sformatf("ack[%0d]", k), W'(ack[k]), W'(ea));
      check($sformatf("result[%0d]", k), result[k], m_res[k]);
      check($sformatf("grant_id[%0d]", k), W'(grant_id[k]), W'(m_gid[k]));
      check($sformatf("busy[%0d]", k), W'(busy[k]), W'(m_phase[k] != 0));
    end
  endtask

  // one clock: compare on the falling edge, return just after the next rising edge
  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(int k, int i, logic [OW-1:0] op, logic [W-1:0] a, logic [W-1:0] b);
    req_op[k][i*OW +: OW] = op;
    req_a[k][i*W +: W]    = a;
    req_b[k][i*W +: W]    = b;
    req[k][i]             = 1'b1;
  endtask

  function automatic int ack_idx(logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  int ord [4];
  int tm  [4];
  int waits [2][N];

  initial begin
    int n, idx, lat;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req[k] = '0; req_op[k] = '0; req_a[k] = '0; req_b[k] = '0; glitch[k] = '0;
      for (int i = 0; i < N; i++) waits[k][i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_sel", W'(alu_sel[0]), 0);
    check("rst_ack", W'(ack[0]), 0);
    check("rst_grant", W'(grant_id[0]), 0);
    check("rst_busy", W'(busy[0]), 0);
    check("rst_result", result[0], 0);
    reset = 1'b0;

    // single ADD from requester 0
    set_req(0, 0, ALU_ADD, 5, 7);
    step();
    check("t1_sel", W'(alu_sel[0]), 0);
    check("t1_a", alu_a[0], 5);
    check("t1_b", alu_b[0], 7);
    check("t1_busy", W'(busy[0]), 1);
    check("t1_alu", alu_result[0], 12);
    step();
    check("t1_ack", W'(ack[0]), 4'b0001);
    check("t1_result", result[0], 12);
    check("t1_grant", W'(grant_id[0]), 0);
    req[0][0] = 1'b0;
    step();
    check("t1_idle_busy", W'(busy[0]), 0);

    // all four contend from a fresh pointer
    pulse_reset();
    for (int i = 0; i < N; i++) set_req(0, i, OW'($urandom_range(0, 7)), $urandom, $urandom);
    for (int i = 0; i < 4; i++) begin ord[i] = -1; tm[i] = 0; end
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      step();
      idx = ack_idx(ack[0]);
      if (idx >= 0) begin
        ord[n] = idx; tm[n] = cyc; req[0][idx] = 1'b0; n++;
      end
    end
    for (int i = 0; i < 4; i++) check($sformatf("t2_order%0d", i), ord[i], i);
    for (int i = 1; i < 4; i++) check($sformatf("t2_gap%0d", i), tm[i] - tm[i-1], 3);

    // requester 1 stays up after its ack; 2 must be served in between
    set_req(0, 1, ALU_SUB, $urandom, $urandom);
    set_req(0, 2, ALU_AND, $urandom, $urandom);
    for (int i = 0; i < 3; i++) ord[i] = -1;
    n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      step();
      idx = ack_idx(ack[0]);
      if (idx >= 0) begin
        ord[n] = idx;
        if (idx == 2 || n == 2) req[0][idx] = 1'b0;
        n++;
      end
    end
    req[0] = '0;
    check("t3_first", ord[0], 1);
    check("t3_second", ord[1], 2);
    check("t3_third", ord[2], 1);
    step();

    // reset in the middle of EXEC
    set_req(0, 2, ALU_XOR, 32'h1234, 32'h00ff);
    step();
    check("t4_grant", W'(grant_id[0]), 2);
    check("t4_busy", W'(busy[0]), 1);
    reset = 1'b1;
    #1;
    check("t4_rst_busy", W'(busy[0]), 0);
    check("t4_rst_ack", W'(ack[0]), 0);
    check("t4_rst_sel", W'(alu_sel[0]), 0);
    check("t4_rst_a", alu_a[0], 0);
    check("t4_rst_b", alu_b[0], 0);
    check("t4_rst_result", result[0], 0);
    check("t4_rst_grant", W'(grant_id[0]), 0);
    step();
    step();
    reset = 1'b0;
    step();
    check("t4_regrant", W'(grant_id[0]), 2);
    check("t4_rebusy", W'(busy[0]), 1);
    step();
    check("t4_ack", W'(ack[0]), 4'b0100);
    check("t4_result", result[0], 32'h12cb);
    req[0][2] = 1'b0;
    step();

    // three-cycle EXEC with the ALU output moving before the last cycle
    set_req(1, 0, ALU_SLT, 3, 9);
    glitch[1] = 32'h55;
    lat = -1;
    for (int c = 1; c <= 10 && lat < 0; c++) begin
      step();
      if (c == 1) check("t5_sel", W'(alu_sel[1]), 7);
      if (ack[1] != '0) lat = c;
      else glitch[1] = (c == 3) ? 32'h100 : 32'h0f0 + W'(c);
    end
    check("t5_latency", lat, 4);
    check("t5_ack", W'(ack[1]), 4'b0001);
    check("t5_result", result[1], 32'h101);
    req[1][0] = 1'b0;
    glitch[1] = '0;
    step();

    // request rising during RESP waits for the next IDLE
    set_req(0, 0, ALU_SUB, 20, 8);
    step();
    step();
    check("t6_ack", W'(ack[0]), 4'b0001);
    req[0][0] = 1'b0;
    set_req(0, 3, ALU_OR, 32'h0f00, 32'h00f0);
    step();
    check("t6_resp_busy", W'(busy[0]), 0);
    check("t6_resp_grant", W'(grant_id[0]), 0);
    step();
    check("t6_grant", W'(grant_id[0]), 3);
    step();
    check("t6_ack3", W'(ack[0]), 4'b1000);
    req[0][3] = 1'b0;
    step();

    // random traffic on both instances
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        glitch[k] = ($urandom_range(0, 1) == 1) ? $urandom : '0;
        idx = ack_idx(ack[k]);
        if (idx >= 0) begin
          check($sformatf("fair[%0d][%0d]", k, idx), W'(waits[k][idx] > N - 1), 0);
          waits[k][idx] = 0;
          for (int j = 0; j < N; j++) if (j != idx && req[k][j]) waits[k][j]++;
          if ($urandom_range(0, 3) != 0) req[k][idx] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
          if (i != idx && !req[k][i] && $urandom_range(0, 2) == 0) begin
            waits[k][i] = 0;
            set_req(k, i, OW'($urandom_range(0, 7)), $urandom, $urandom);
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
